// File: rtl/softmax_stream_sequencer.sv
// Stream-side controller for the N-lane softmax core: gathers a frame of N
// scores, launches one softmax operation with a timeout guard, then streams the N results out.

module softmax_stream_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_we_i,
    input  logic [W-1:0] in_d_i,
    input  logic         out_we_i,
    input  logic [W-1:0] out_d_i,
    output logic [W-1:0] in_q_o,
    output logic [W-1:0] out_q_o
);
    logic [W-1:0] in_el_q, out_el_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_el_q  <= '0;
            out_el_q <= '0;
        end else begin
            if (in_we_i)  in_el_q  <= in_d_i;
            if (out_we_i) out_el_q <= out_d_i;
        end
    end

    assign in_q_o  = in_el_q;
    assign out_q_o = out_el_q;
endmodule

module softmax_stream_sequencer #(
    parameter int N       = 64,
    parameter int W       = 16,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    input  logic [W-1:0]   s_data,
    output logic           s_ready,
    output logic           sm_valid_in,
    output logic           sm_en,
    output logic [N*W-1:0] sm_in_x_flat,
    input  logic           sm_valid_out,
    input  logic [N*W-1:0] sm_prob_flat,
    output logic           m_valid,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    input  logic           m_ready,
    output logic           busy,
    output logic           timeout_err,
    input  logic           err_clr
);
    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       in_idx_q, in_idx_d;
    logic [IW-1:0]       out_idx_q, out_idx_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                rdy_q;
    logic                err_q, err_d;
    logic                s_acc, capture, timeout;
    logic [N-1:0]        in_we;
    logic [N-1:0][W-1:0] in_vec, out_vec;

    // rdy_q keeps s_ready low while reset is held and for the cycle it is released
    assign s_ready = rdy_q && (state_q == S_LOAD);
    assign s_acc   = s_valid && s_ready;

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign in_we[k] = s_acc && (in_idx_q == IW'(k));
        softmax_stream_lane #(.W(W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_we_i  (in_we[k]),
            .in_d_i   (s_data),
            .out_we_i (capture),
            .out_d_i  (sm_prob_flat[k*W +: W]),
            .in_q_o   (in_vec[k]),
            .out_q_o  (out_vec[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            wait_cnt_q <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_idx_q   <= in_idx_d;
            out_idx_q  <= out_idx_d;
            wait_cnt_q <= wait_cnt_d;
            rdy_q      <= 1'b1;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (s_acc) begin
                    if (in_idx_q == LAST_IDX) begin
                        in_idx_d = '0;
                        state_d  = S_LAUNCH;
                    end else begin
                        in_idx_d = in_idx_q + IW'(1);
                    end
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CW'(1);
                // a result arriving on the last allowed cycle still wins over the timeout
                if (sm_valid_out) begin
                    capture   = 1'b1;
                    out_idx_d = '0;
                    state_d   = S_DRAIN;
                end else if (wait_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_idx_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        out_idx_d = out_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (timeout) err_d = 1'b1;
    end

    assign sm_valid_in  = (state_q == S_LAUNCH);
    assign sm_en        = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign sm_in_x_flat = in_vec;
    assign m_valid      = (state_q == S_DRAIN);
    assign m_data       = out_vec[out_idx_q];
    assign m_last       = (state_q == S_DRAIN) && (out_idx_q == LAST_IDX);
    assign busy         = (state_q != S_LOAD) || (in_idx_q != '0);
    assign timeout_err  = err_q;
endmodule

// File: tb/tb_softmax_stream_sequencer.sv
// Randomized bench for softmax_stream_sequencer: a frame-level reference model
// predicts handshakes, launch vectors, drained results and the timeout flag.
module tb_softmax_stream_sequencer;
    localparam int N = 4, W = 16, TO = 8, CW = 8;

    logic           clk = 0, rst = 1;
    logic           s_valid = 0, s_ready;
    logic [W-1:0]   s_data = 0;
    logic           sm_valid_in, sm_en, sm_valid_out = 0;
    logic [N*W-1:0] sm_in_x_flat, sm_prob_flat = 0;
    logic           m_valid, m_last, m_ready = 0;
    logic [W-1:0]   m_data;
    logic           busy, timeout_err, err_clr = 0;

    always #5 clk = ~clk;

    softmax_stream_sequencer #(.N(N), .W(W), .TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sm_valid_in(sm_valid_in), .sm_en(sm_en), .sm_in_x_flat(sm_in_x_flat),
        .sm_valid_out(sm_valid_out), .sm_prob_flat(sm_prob_flat),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // stimulus state
    logic [W-1:0]   src_q[$];
    int             sv_pct = 100, mr_pct = 100, clr_pct = 0;
    bit             clr_force = 0, rand_resp = 0, rand_prob = 0;
    int             resp_delay = 3, resp_cnt = 0;
    logic [N*W-1:0] resp_prob = 0;
    int             mcount = 0, bp_idx = -1, bp_left = 0;

    // reference model state
    logic [W-1:0]   part_q[$], out_q[$], log_d[$];
    logic [N*W-1:0] frame_q[$];
    int             log_c[$];
    bit             launch_exp = 0, inflight = 0, err_m = 0, post_rst = 0;
    int             wait_k = 0, drain_rem = 0, cyc_n = 0;

    function automatic bit idle();
        return src_q.size() == 0 && part_q.size() == 0 && !launch_exp && !inflight && drain_rem == 0;
    endfunction

    task automatic cyc();
        bit took_s, took_m, took_last;
        took_s    = s_valid && s_ready;
        took_m    = m_valid && m_ready;
        took_last = took_m && m_last;
        @(posedge clk); #1;
        if (took_s) void'(src_q.pop_front());
        if (took_m) mcount = took_last ? 0 : mcount + 1;
        s_valid = (src_q.size() != 0) && (int'($urandom_range(99)) < sv_pct);
        s_data  = (src_q.size() != 0) ? src_q[0] : W'($urandom);
        if (bp_left > 0 && m_valid && mcount == bp_idx) begin
            m_ready = 0;
            bp_left--;
        end else begin
            m_ready = int'($urandom_range(99)) < mr_pct;
        end
        err_clr = clr_force || (int'($urandom_range(99)) < clr_pct);
        // softmax core stand-in: answer resp_cnt cycles after the launch (0 = never)
        sm_valid_out = 0;
        if (sm_valid_in) begin
            resp_cnt     = rand_resp ? int'($urandom_range(11)) : resp_delay;
            sm_prob_flat = rand_prob ? {$urandom, $urandom} : resp_prob;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            sm_valid_out = (resp_cnt == 0);
        end
    endtask

    // frame-level model, evaluated mid-cycle while all inputs are stable
    always @(negedge clk) begin
        if (!rst) begin
            part_q.delete(); frame_q.delete(); out_q.delete();
            launch_exp = 0; inflight = 0; err_m = 0; drain_rem = 0; post_rst = 1;
        end else begin
            bit to_now;
            logic [N*W-1:0] f;
            cyc_n++;
            chk("s_ready", s_ready, !post_rst && !launch_exp && !inflight && drain_rem == 0);
            post_rst = 0;
            chk("sm_valid_in", sm_valid_in, launch_exp);
            chk("sm_en", sm_en, launch_exp || inflight);
            chk("m_valid", m_valid, drain_rem != 0);
            chk("busy", busy, launch_exp || inflight || drain_rem != 0 || part_q.size() != 0);
            chk("timeout_err", timeout_err, err_m);
            if (launch_exp) chk("sm_in_x_flat", sm_in_x_flat, frame_q.pop_front());
            if (drain_rem != 0) begin
                chk("m_data", m_data, out_q[0]);
                chk("m_last", m_last, drain_rem == 1);
                if (m_ready) begin
                    log_d.push_back(m_data);
                    log_c.push_back(cyc_n);
                    void'(out_q.pop_front());
                    drain_rem--;
                end
            end
            to_now = 0;
            if (inflight) begin
                wait_k++;
                if (sm_valid_out) begin
                    for (int k = 0; k < N; k++) out_q.push_back(sm_prob_flat[k*W +: W]);
                    drain_rem = N;
                    inflight  = 0;
                end else if (wait_k == TO) begin
                    to_now   = 1;
                    inflight = 0;
                end
            end
            if (launch_exp) begin
                inflight = 1; wait_k = 0; launch_exp = 0;
            end
            if (err_clr) err_m = 0;
            if (to_now)  err_m = 1;
            if (s_valid && s_ready) begin
                part_q.push_back(s_data);
                if (part_q.size() == N) begin
                    for (int k = 0; k < N; k++) f[k*W +: W] = part_q[k];
                    frame_q.push_back(f);
                    part_q.delete();
                    launch_exp = 1;
                end
            end
        end
    end

    task automatic wait_launch(output int n);
        n = 0;
        do begin cyc(); n++; end while (!sm_valid_in && n < 40);
        chk("launch_seen", sm_valid_in, 1);
    endtask

    task automatic run_idle(input int max, input string tag);
        int n = 0;
        do begin cyc(); n++; end while (!idle() && n < max);
        chk({tag, "_idle"}, idle(), 1);
    endtask

    task automatic push4(input logic [W-1:0] a, b, c, d);
        src_q.push_back(a); src_q.push_back(b); src_q.push_back(c); src_q.push_back(d);
    endtask

    task automatic chk_log(input string tag, input logic [N*W-1:0] exp);
        chk({tag, "_cnt"}, log_d.size(), N);
        if (log_d.size() == N)
            for (int k = 0; k < N; k++) chk({tag, "_elem"}, log_d[k], exp[k*W +: W]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        #2 rst = 0;
        @(posedge clk); #1;
        chk("rst_ctrl", {s_ready, sm_valid_in, sm_en, m_valid, m_last, busy, timeout_err}, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_inx", sm_in_x_flat, 0);
        @(posedge clk); #1 rst = 1;
        cyc(); cyc();

        // back-to-back frame, response 3 cycles after launch, sink always ready
        resp_delay = 3; resp_prob = 64'h4000_2000_1000_0800;
        log_d.delete(); log_c.delete();
        push4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        wait_launch(n);
        chk("t1_launch_lat", n, 5);
        chk("t1_frame", sm_in_x_flat, 64'h0400_0300_0200_0100);
        run_idle(40, "t1");
        chk_log("t1_out", 64'h4000_2000_1000_0800);
        if (log_c.size() == N) chk("t1_consec", log_c[N-1] - log_c[0], N - 1);

        // same frame, element 1 held off by 5 cycles of backpressure
        log_d.delete(); log_c.delete();
        bp_idx = 1; bp_left = 5;
        push4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        run_idle(60, "t3");
        chk_log("t3_out", 64'h4000_2000_1000_0800);
        if (log_c.size() == N) chk("t3_span", log_c[N-1] - log_c[0], N - 1 + 5);
        bp_idx = -1;

        // core never answers: timeout, then clear
        log_d.delete(); log_c.delete();
        resp_delay = 0;
        push4(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        wait_launch(n);
        n = 0;
        do begin cyc(); n++; end while (!timeout_err && n < 30);
        chk("t4_to_lat", n, TO + 1);
        chk("t4_ready", s_ready, 1);
        chk("t4_busy", busy, 0);
        chk("t4_no_out", log_d.size(), 0);
        clr_force = 1; cyc(); clr_force = 0; cyc();
        chk("t4_clr", timeout_err, 0);

        // response on the last allowed WAIT cycle is taken, no error
        log_d.delete(); log_c.delete();
        resp_delay = TO; resp_prob = 64'h7fff_0001_8000_1234;
        push4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        run_idle(60, "t6");
        chk("t6_err", timeout_err, 0);
        chk_log("t6_out", 64'h7fff_0001_8000_1234);

        // reset with a half-loaded frame
        resp_delay = 3; resp_prob = 64'h0004_0003_0002_0001;
        push4(16'hdead, 16'hbeef, 16'hcafe, 16'hf00d);
        cyc(); cyc(); cyc();
        #2 rst = 0;
        #1;
        chk("t5_rst_ctrl", {s_ready, sm_valid_in, sm_en, m_valid, m_last, busy, timeout_err}, 0);
        chk("t5_rst_inx", sm_in_x_flat, 0);
        chk("t5_rst_mdata", m_data, 0);
        src_q.delete(); s_valid = 0; resp_cnt = 0; mcount = 0;
        @(posedge clk); #1 rst = 1;
        cyc(); cyc();
        log_d.delete(); log_c.delete();
        push4(16'h000a, 16'h000b, 16'h000c, 16'h000d);
        wait_launch(n);
        chk("t5_frame", sm_in_x_flat, 64'h000d_000c_000b_000a);
        run_idle(60, "t5");
        chk_log("t5_out", 64'h0004_0003_0002_0001);

        // randomized traffic: gaps, backpressure, latencies incl. timeouts and late responses
        rand_resp = 1; rand_prob = 1; sv_pct = 70; mr_pct = 70; clr_pct = 5;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < N; k++) src_q.push_back(W'($urandom));
            run_idle(300, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
